gamma_loader: RTL and testbench



---
 rtl/gamma_loader_if.sv | 36 +++
 rtl/gamma_loader.sv | 132 +++++++++++++
 tb/tb_gamma_loader.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/gamma_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : gamma_loader_if
// Brief    : Command, byte-stream and gamma-RAM write signals of gamma_loader.
// Revision : 1.0 - initial release
// ============================================================================
interface gamma_loader_if;
   logic       cmd_start;
   logic       linear_req;
   logic       en_wr;
   logic       en_val;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       gamma_en;
   logic       gamma_wr;
   logic [9:0] gamma_wr_addr;
   logic [7:0] gamma_value;
   logic       busy;
   logic       done;
   logic       err;

   // master is the loader itself; slave is the HPS side plus the gamma stage
   modport master (
      input  cmd_start, linear_req, en_wr, en_val, in_valid, in_data,
      output in_ready, gamma_en, gamma_wr, gamma_wr_addr, gamma_value,
             busy, done, err
   );

   modport slave (
      output cmd_start, linear_req, en_wr, en_val, in_valid, in_data,
      input  in_ready, gamma_en, gamma_wr, gamma_wr_addr, gamma_value,
             busy, done, err
   );
endinterface
`default_nettype wire

// File: rtl/gamma_loader.sv
`default_nettype none
// ============================================================================
// Module   : gamma_loader
// Brief    : Fills the 768-entry gamma RAM from a byte stream or an identity
//            curve, and owns the gamma_en control bit.
// Revision : 1.0 - initial release
// ============================================================================
module gamma_loader #(
   parameter bit GEN_ON_RESET = 1'b1
) (
   input  wire logic      clk_sys,
   input  wire logic      reset,
   gamma_loader_if.master bus
);
   localparam logic [9:0] c_LAST_IDX = 10'd767;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_GEN  = 2'd2
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [9:0] r_cnt;
   logic [9:0] w_cnt_nxt;
   logic       r_boot;
   logic       r_pend_vld;
   logic       r_pend_val;
   logic       w_pend_vld;
   logic       w_pend_val;
   logic       w_wr;
   logic       w_done;
   logic       w_err;
   logic [7:0] w_value;

   assign bus.in_ready = (r_state == S_LOAD);

   // An en_wr arriving in the final cycle of a session still lands at done
   assign w_pend_vld = r_pend_vld | bus.en_wr;
   assign w_pend_val = bus.en_wr ? bus.en_val : r_pend_val;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_wr        = 1'b0;
      w_value     = 8'd0;
      w_done      = 1'b0;
      w_err       = 1'b0;

      if (bus.cmd_start) begin
         w_state_nxt = S_LOAD;
         w_cnt_nxt   = 10'd0;
         w_err       = (r_state != S_IDLE);
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.linear_req || r_boot) begin
                  w_state_nxt = S_GEN;
                  w_cnt_nxt   = 10'd0;
               end
            end
            S_LOAD: begin
               if (bus.in_valid) begin
                  w_wr    = 1'b1;
                  w_value = bus.in_data;
               end
            end
            S_GEN: begin
               w_wr    = 1'b1;
               w_value = r_cnt[7:0];
            end
            default: w_state_nxt = S_IDLE;
         endcase

         if (w_wr) begin
            if (r_cnt == c_LAST_IDX) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = 10'd0;
               w_done      = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 10'd1;
            end
         end
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_state           <= S_IDLE;
         r_cnt             <= 10'd0;
         r_boot            <= GEN_ON_RESET;
         r_pend_vld        <= 1'b0;
         r_pend_val        <= 1'b0;
         bus.gamma_en      <= 1'b0;
         bus.gamma_wr      <= 1'b0;
         bus.gamma_wr_addr <= 10'd0;
         bus.gamma_value   <= 8'd0;
         bus.busy          <= 1'b0;
         bus.done          <= 1'b0;
         bus.err           <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_boot       <= 1'b0;
         bus.gamma_wr <= w_wr;
         bus.done     <= w_done;
         bus.err      <= w_err;
         bus.busy     <= (w_state_nxt != S_IDLE);

         if (w_wr) begin
            bus.gamma_wr_addr <= r_cnt;
            bus.gamma_value   <= w_value;
         end

         if (r_state == S_IDLE) begin
            if (bus.en_wr) begin
               bus.gamma_en <= bus.en_val;
            end
         end else if (w_done) begin
            if (w_pend_vld) begin
               bus.gamma_en <= w_pend_val;
            end
            r_pend_vld <= 1'b0;
         end else begin
            r_pend_vld <= w_pend_vld;
            r_pend_val <= w_pend_val;
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_gamma_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_gamma_loader
// Brief    : Directed/random bench for gamma_loader against a session-level
//            reference model of the loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gamma_loader;
   localparam bit c_GEN_ON_RESET = 1'b1;
   localparam int c_ENTRIES      = 768;

   logic clk_sys;
   logic reset;
   gamma_loader_if bus();

   gamma_loader #(.GEN_ON_RESET(c_GEN_ON_RESET)) dut (
      .clk_sys (clk_sys),
      .reset   (reset),
      .bus     (bus)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   int checks = 0;
   int errors = 0;

   // Reference model: mode 0 idle, 1 stream load, 2 identity generation
   int         m_mode;
   int         m_written;
   bit         m_boot;
   bit         m_pend;
   bit         m_pend_val;
   logic       e_wr, e_done, e_err, e_busy, e_en;
   logic [9:0] e_addr;
   logic [7:0] e_val;

   // Observed activity, tallied from the DUT outputs
   int         writes_seen;
   int         dones_seen;
   int         errs_seen;
   logic [7:0] val_1ff;
   logic [7:0] val_100;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic emit(input int v);
      e_wr   = 1'b1;
      e_addr = m_written[9:0];
      e_val  = v[7:0];
      m_written++;
      if (m_written == c_ENTRIES) begin
         m_mode = 0;
         e_done = 1'b1;
         if (m_pend) begin
            e_en   = m_pend_val;
            m_pend = 1'b0;
         end
      end
   endtask

   task automatic model_step();
      if (reset) begin
         m_mode = 0; m_written = 0; m_boot = c_GEN_ON_RESET;
         m_pend = 1'b0; m_pend_val = 1'b0;
         e_wr = 1'b0; e_addr = '0; e_val = '0; e_done = 1'b0;
         e_err = 1'b0; e_en = 1'b0; e_busy = 1'b0;
      end else begin
         e_wr = 1'b0; e_done = 1'b0; e_err = 1'b0;
         if (bus.en_wr) begin
            if (m_mode == 0) e_en = bus.en_val;
            else begin
               m_pend     = 1'b1;
               m_pend_val = bus.en_val;
            end
         end
         if (bus.cmd_start) begin
            e_err     = (m_mode != 0);
            m_mode    = 1;
            m_written = 0;
         end else if (m_mode == 0) begin
            if (bus.linear_req || m_boot) begin
               m_mode    = 2;
               m_written = 0;
            end
         end else if (m_mode == 1) begin
            if (bus.in_valid) emit(int'(bus.in_data));
         end else begin
            emit(m_written % 256);
         end
         m_boot = 1'b0;
         e_busy = (m_mode != 0);
      end
   endtask

   task automatic check_all();
      chk("gamma_wr",   bus.gamma_wr,      e_wr);
      chk("wr_addr",    bus.gamma_wr_addr, e_addr);
      chk("value",      bus.gamma_value,   e_val);
      chk("done",       bus.done,          e_done);
      chk("err",        bus.err,           e_err);
      chk("busy",       bus.busy,          e_busy);
      chk("gamma_en",   bus.gamma_en,      e_en);
      chk("in_ready",   bus.in_ready,      (m_mode == 1));
      if (bus.gamma_wr === 1'b1) begin
         writes_seen++;
         if (bus.gamma_wr_addr == 10'h1FF) val_1ff = bus.gamma_value;
         if (bus.gamma_wr_addr == 10'h100) val_100 = bus.gamma_value;
      end
      if (bus.done === 1'b1) dones_seen++;
      if (bus.err === 1'b1) errs_seen++;
   endtask

   task automatic step();
      model_step();
      @(posedge clk_sys);
      #1;
      check_all();
   endtask

   task automatic clear_tallies();
      writes_seen = 0; dones_seen = 0; errs_seen = 0;
      val_1ff = 8'h00; val_100 = 8'h00;
   endtask

   // Offer bytes until n have been accepted; gap_pct is the idle percentage
   task automatic feed(input int n, input int gap_pct, input bit inv);
      int acc   = 0;
      int guard = 0;
      while (acc < n && guard < 20000) begin
         bus.in_valid = ($urandom_range(0, 99) >= gap_pct);
         bus.in_data  = inv ? ~m_written[7:0] : 8'($urandom_range(0, 255));
         if (bus.in_valid && m_mode == 1) acc++;
         step();
         guard++;
      end
      bus.in_valid = 1'b0;
      chk("feed_timeout", (guard < 20000), 1);
   endtask

   task automatic wait_done(input int bound, output int cyc);
      int d0 = dones_seen;
      cyc = 0;
      while (dones_seen == d0 && cyc < bound) begin
         step();
         cyc++;
      end
      chk("done_timeout", (dones_seen != d0), 1);
   endtask

   task automatic pulse_cmd(input bit with_linear);
      bus.cmd_start  = 1'b1;
      bus.linear_req = with_linear;
      step();
      bus.cmd_start  = 1'b0;
      bus.linear_req = 1'b0;
   endtask

   initial begin
      int cyc;
      reset          = 1'b1;
      bus.cmd_start  = 1'b0;
      bus.linear_req = 1'b0;
      bus.en_wr      = 1'b0;
      bus.en_val     = 1'b0;
      bus.in_valid   = 1'b0;
      bus.in_data    = 8'h00;
      clear_tallies();
      repeat (3) step();

      // Automatic identity curve after reset release
      reset = 1'b0;
      clear_tallies();
      wait_done(2000, cyc);
      chk("boot_done_cycle", cyc, 769);
      chk("boot_writes", writes_seen, c_ENTRIES);
      chk("boot_val_1ff", val_1ff, 8'hFF);
      step();

      // en_wr in IDLE applies next cycle
      bus.en_wr = 1'b1; bus.en_val = 1'b1;
      step();
      bus.en_wr = 1'b0;
      chk("en_idle", bus.gamma_en, 1);

      // Back-to-back stream of ~cnt with a deferred enable clear
      clear_tallies();
      pulse_cmd(1'b0);
      chk("load_ready", bus.in_ready, 1);
      feed(200, 0, 1'b1);
      bus.en_wr = 1'b1; bus.en_val = 1'b0;
      feed(1, 0, 1'b1);
      bus.en_wr = 1'b0;
      feed(566, 0, 1'b1);
      chk("en_held", bus.gamma_en, 1);
      feed(1, 0, 1'b1);
      chk("load_done", bus.done, 1);
      chk("en_at_done", bus.gamma_en, 0);
      chk("load_writes", writes_seen, c_ENTRIES);
      chk("load_val_100", val_100, 8'hFF);
      chk("load_dones", dones_seen, 1);

      // Random valid gaps
      clear_tallies();
      pulse_cmd(1'b0);
      feed(c_ENTRIES, 30, 1'b0);
      repeat (3) step();
      chk("gap_writes", writes_seen, c_ENTRIES);
      chk("gap_dones", dones_seen, 1);

      // Abort after 300 accepted bytes
      pulse_cmd(1'b0);
      feed(300, 20, 1'b0);
      clear_tallies();
      bus.in_valid = 1'b1;
      pulse_cmd(1'b0);
      bus.in_valid = 1'b0;
      chk("abort_err", errs_seen, 1);
      chk("abort_no_wr", writes_seen, 0);
      feed(1, 0, 1'b0);
      chk("abort_first_addr", bus.gamma_wr_addr, 0);
      feed(767, 30, 1'b0);
      chk("abort_writes", writes_seen, c_ENTRIES);
      chk("abort_dones", dones_seen, 1);
      chk("abort_errs", errs_seen, 1);

      // cmd_start beats linear_req; linear_req in LOAD ignored; reset mid-load
      pulse_cmd(1'b1);
      chk("both_ready", bus.in_ready, 1);
      bus.linear_req = 1'b1;
      step();
      bus.linear_req = 1'b0;
      feed(400, 0, 1'b0);
      reset = 1'b1;
      step();
      chk("rst_wr", bus.gamma_wr, 0);
      chk("rst_busy", bus.busy, 0);
      reset = 1'b0;
      clear_tallies();
      wait_done(2000, cyc);
      chk("reboot_writes", writes_seen, c_ENTRIES);
      chk("reboot_errs", errs_seen, 0);

      // Abort an identity generation, then reload
      clear_tallies();
      bus.linear_req = 1'b1;
      step();
      bus.linear_req = 1'b0;
      repeat (50) step();
      pulse_cmd(1'b0);
      feed(c_ENTRIES, 10, 1'b0);
      chk("gen_abort_errs", errs_seen, 1);
      chk("gen_abort_dones", dones_seen, 1);
      chk("gen_abort_writes", writes_seen, 50 + c_ENTRIES);
      repeat (2) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
